// File: rtl/serial_comparator_controller_if.sv
// Request/result bundle between a requesting datapath and the serial comparator.
// master = requester side, slave = comparator controller side.
interface serial_comparator_controller_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
);
    logic             Start_In;
    logic             Signed_In;
    logic             Abort_In;
    logic [WIDTH-1:0] Data_A_In;
    logic [WIDTH-1:0] Data_B_In;
    logic             Ready_Out;
    logic             Busy_Out;
    logic             Done_Out;
    logic             A_Less_Than_B_Out;
    logic             A_Equal_To_B_Out;
    logic             A_Greater_Than_B_Out;
    logic [CNT_W:0]   Bits_Used_Out;

    modport master (
        output Start_In, Signed_In, Abort_In, Data_A_In, Data_B_In,
        input  Ready_Out, Busy_Out, Done_Out,
        input  A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out, Bits_Used_Out
    );

    modport slave (
        input  Start_In, Signed_In, Abort_In, Data_A_In, Data_B_In,
        output Ready_Out, Busy_Out, Done_Out,
        output A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out, Bits_Used_Out
    );
endinterface

// File: rtl/serial_comparator_controller.sv
// MSB-first bit-serial magnitude compare with early exit; Done_Out n+1 cycles after accept.
// Accepts only when Ready_Out (IDLE); Start_In elsewhere is dropped, Abort_In cancels COMPARE.
module serial_comparator_controller #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic Clock_In,
    input  logic Reset_In,
    serial_comparator_controller_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] IDX_MSB   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W:0]   BITS_FULL = (CNT_W + 1)'(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [CNT_W-1:0] r_idx;
    logic             r_lt;
    logic             r_eq;
    logic             r_gt;
    logic [CNT_W:0]   r_bits;

    logic w_a_bit;
    logic w_b_bit;
    logic w_invert;
    logic w_differ;
    logic w_gt_bit;
    logic w_accept;
    logic w_finish;

    // One-bit slice; the sign bit of a two's-complement pair compares with inverted polarity.
    assign w_a_bit  = r_a[r_idx];
    assign w_b_bit  = r_b[r_idx];
    assign w_invert = r_signed && (r_idx == IDX_MSB);
    assign w_differ = w_a_bit ^ w_b_bit;
    assign w_gt_bit = w_a_bit ^ w_invert;

    assign w_accept = (r_state == ST_IDLE) && bus.Start_In;
    assign w_finish = (r_state == ST_COMPARE) && !bus.Abort_In
                      && (w_differ || (r_idx == '0));

    always_ff @(posedge Clock_In or negedge Reset_In) begin
        if (!Reset_In) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.Start_In) begin
                    w_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (bus.Abort_In) begin
                    w_next = ST_IDLE;
                end else if (w_finish) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_In or negedge Reset_In) begin
        if (!Reset_In) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_bits   <= '0;
        end else if (w_accept) begin
            r_a      <= bus.Data_A_In;
            r_b      <= bus.Data_B_In;
            r_signed <= bus.Signed_In;
            r_idx    <= IDX_MSB;
        end else if (w_finish) begin
            r_lt   <= w_differ && !w_gt_bit;
            r_eq   <= !w_differ;
            r_gt   <= w_differ && w_gt_bit;
            r_bits <= BITS_FULL - {1'b0, r_idx};
        end else if ((r_state == ST_COMPARE) && !bus.Abort_In) begin
            r_idx <= r_idx - CNT_W'(1);
        end
    end

    assign bus.Ready_Out            = (r_state == ST_IDLE);
    assign bus.Busy_Out             = (r_state == ST_COMPARE);
    assign bus.Done_Out             = (r_state == ST_DONE);
    assign bus.A_Less_Than_B_Out    = r_lt;
    assign bus.A_Equal_To_B_Out     = r_eq;
    assign bus.A_Greater_Than_B_Out = r_gt;
    assign bus.Bits_Used_Out        = r_bits;
endmodule

// File: tb/tb_serial_comparator_controller.sv
// Randomized bench for serial_comparator_controller against a cycle-count behavioural model.
module tb_serial_comparator_controller;
    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_comparator_controller_if #(.WIDTH(W)) bus();

    serial_comparator_controller #(.WIDTH(W)) dut (
        .Clock_In (clk),
        .Reset_In (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
        int   n;
    } res_t;

    // Reference result: arithmetic compare, bits examined = position of first differing bit.
    function automatic res_t calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        res_t         r;
        logic [W-1:0] d;
        r   = '0;
        d   = a ^ b;
        r.n = W;
        for (int i = 0; i < W; i++) begin
            if (d[i]) r.n = W - i;
        end
        if (d == '0)                                    r.eq = 1'b1;
        else if (s ? ($signed(a) < $signed(b)) : (a < b)) r.lt = 1'b1;
        else                                            r.gt = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: m_t counts cycles since accept; COMPARE spans 1..n, Done at n+1.
    bit   m_act  = 1'b0;
    int   m_t    = 0;
    res_t p_res  = '0;
    logic m_lt   = 1'b0;
    logic m_eq   = 1'b0;
    logic m_gt   = 1'b0;
    int   m_bits = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act  <= 1'b0;
            m_t    <= 0;
            p_res  <= '0;
            m_lt   <= 1'b0;
            m_eq   <= 1'b0;
            m_gt   <= 1'b0;
            m_bits <= 0;
        end else if (!m_act) begin
            if (bus.Start_In) begin
                p_res <= calc(bus.Data_A_In, bus.Data_B_In, bus.Signed_In);
                m_act <= 1'b1;
                m_t   <= 1;
            end
        end else if (m_t <= p_res.n) begin
            if (bus.Abort_In) begin
                m_act <= 1'b0;
            end else begin
                if (m_t == p_res.n) begin
                    m_lt   <= p_res.lt;
                    m_eq   <= p_res.eq;
                    m_gt   <= p_res.gt;
                    m_bits <= p_res.n;
                end
                m_t <= m_t + 1;
            end
        end else begin
            m_act <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", bus.Ready_Out, !m_act);
            chk("busy",  bus.Busy_Out,  m_act && (m_t <= p_res.n));
            chk("done",  bus.Done_Out,  m_act && (m_t == p_res.n + 1));
            chk("lt",    bus.A_Less_Than_B_Out,    m_lt);
            chk("eq",    bus.A_Equal_To_B_Out,     m_eq);
            chk("gt",    bus.A_Greater_Than_B_Out, m_gt);
            chk("bits",  bus.Bits_Used_Out,        m_bits);
        end
    end

    // Called #1 after a rising edge with the DUT idle. lat = edges from accept to Done
    // (accept edge counts as 1), or -(edges until Ready returned) after an abort.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int abort_cyc, input bit hold, output int lat);
        bus.Data_A_In = a;
        bus.Data_B_In = b;
        bus.Signed_In = s;
        bus.Start_In  = 1'b1;
        bus.Abort_In  = 1'b0;
        lat = 0;
        for (int c = 1; c <= W + 3; c++) begin
            @(posedge clk);
            #1;
            if (bus.Ready_Out) begin
                bus.Start_In = 1'b0;
                bus.Abort_In = 1'b0;
                lat = -c;
                return;
            end
            bus.Start_In  = hold;
            bus.Abort_In  = (c == abort_cyc);
            bus.Data_A_In = W'($urandom);
            bus.Data_B_In = W'($urandom);
            bus.Signed_In = 1'($urandom);
            if (bus.Done_Out) begin
                bus.Start_In = 1'b0;
                @(posedge clk);
                #1;
                bus.Abort_In = 1'b0;
                lat = c;
                return;
            end
        end
        chk("timeout", 32'd0, 32'd1);
        bus.Start_In = 1'b0;
        bus.Abort_In = 1'b0;
    endtask

    task automatic expect_res(input string nm, input logic lt, input logic eq, input logic gt,
                              input int bits);
        chk({nm, "_lt"},   bus.A_Less_Than_B_Out,    lt);
        chk({nm, "_eq"},   bus.A_Equal_To_B_Out,     eq);
        chk({nm, "_gt"},   bus.A_Greater_Than_B_Out, gt);
        chk({nm, "_bits"}, bus.Bits_Used_Out,        bits);
    endtask

    initial begin
        int           lat;
        res_t         r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        int           ab;
        bit           hs;

        bus.Start_In  = 1'b0;
        bus.Signed_In = 1'b0;
        bus.Abort_In  = 1'b0;
        bus.Data_A_In = '0;
        bus.Data_B_In = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", bus.Ready_Out, 1);
        chk("rst_busy",  bus.Busy_Out,  0);
        chk("rst_done",  bus.Done_Out,  0);
        expect_res("rst", 0, 0, 0, 0);

        r = calc(8'hA5, 8'h25, 1'b0);
        chk("pin_a5_gt", r.gt, 1);
        chk("pin_a5_n",  r.n,  1);
        r = calc(8'hFF, 8'h01, 1'b1);
        chk("pin_ff_s_lt", r.lt, 1);

        run_op(8'hA5, 8'h25, 1'b0, 0, 1'b0, lat);
        chk("lat_a5", lat, 2);
        expect_res("a5", 0, 0, 1, 1);
        run_op(8'h3C, 8'h3C, 1'b0, 0, 1'b0, lat);
        chk("lat_eq", lat, 9);
        expect_res("eq3c", 0, 1, 0, 8);
        run_op(8'h3C, 8'h3D, 1'b0, 0, 1'b0, lat);
        chk("lat_3d", lat, 9);
        expect_res("lt3d", 1, 0, 0, 8);
        run_op(8'hFF, 8'h01, 1'b1, 0, 1'b0, lat);
        expect_res("sgn", 1, 0, 0, 1);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, lat);
        expect_res("uns", 0, 0, 1, 1);

        run_op(8'h00, 8'h01, 1'b0, 3, 1'b1, lat);
        chk("abort_ready_edge", lat, -4);
        chk("abort_ready", bus.Ready_Out, 1);
        expect_res("abort_hold", 0, 0, 1, 1);

        // Asynchronous reset between edges in the middle of a compare.
        bus.Data_A_In = 8'h00;
        bus.Data_B_In = 8'h01;
        bus.Signed_In = 1'b0;
        bus.Start_In  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start_In = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("mid_busy", bus.Busy_Out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", bus.Ready_Out, 1);
        chk("arst_busy",  bus.Busy_Out,  0);
        chk("arst_done",  bus.Done_Out,  0);
        expect_res("arst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(8'hA5, 8'h25, 1'b0, 0, 1'b0, lat);
        chk("post_rst_lat", lat, 2);
        expect_res("post_rst", 0, 0, 1, 1);

        for (int k = 0; k < 300; k++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = W'($urandom);
                1:       b = a;
                2:       b = a ^ (W'(1) << $urandom_range(0, W - 1));
                default: b = a ^ 8'h80;
            endcase
            s  = 1'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            hs = 1'($urandom);
            r  = calc(a, b, s);
            run_op(a, b, s, ab, hs, lat);
            if (ab == 0 || ab > r.n) chk("rnd_lat", lat, r.n + 1);
            else                     chk("rnd_abort", lat, -(ab + 1));
            if ($urandom_range(0, 1) == 1) begin
                bus.Abort_In = 1'($urandom);
                @(posedge clk);
                #1;
                bus.Abort_In = 1'b0;
            end
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
